// File: rtl/hog_block_gather.sv
// Gathers raster-order 9-bin cell histograms into overlapping 2x2-cell HOG blocks
// with a raster block index and L1 sum, using a one-row line buffer.
module hog_block_gather #(
   parameter int unsigned BIN_W     = 32,
   parameter int unsigned CELL_COLS = 40,
   parameter int unsigned CELL_ROWS = 30,
   parameter int unsigned ADDR_W    = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic [ADDR_W-1:0]      i_addr,
   input  logic [9*BIN_W-1:0]     i_bin,
   output logic                   o_valid,
   output logic [ADDR_W-1:0]      o_blk_addr,
   output logic [36*BIN_W-1:0]    o_block,
   output logic [BIN_W+5:0]       o_l1,
   output logic                   o_err
);

   localparam int unsigned CELL_W  = 9 * BIN_W;
   localparam int unsigned BLK_W   = 4 * CELL_W;
   localparam int unsigned L1_W    = BIN_W + 6;
   localparam int unsigned COL_W   = $clog2(CELL_COLS);
   localparam int unsigned ROW_W   = $clog2(CELL_ROWS);
   localparam int unsigned N_CELLS = CELL_COLS * CELL_ROWS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(CELL_COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(CELL_ROWS - 1);

   typedef enum logic {WAIT_SOF, RUN} state_t;

   state_t              state, state_nxt;
   logic                accept_c, mismatch_c, emit_c, sof_c;
   logic [ADDR_W-1:0]   exp_addr, blk_cnt;
   logic [COL_W-1:0]    col, cur_col;
   logic [ROW_W-1:0]    row, cur_row;

   logic [CELL_W-1:0]   prevrow [CELL_COLS];
   logic                p_valid, s1_valid;
   logic [ADDR_W-1:0]   p_addr, s1_addr;
   logic [CELL_W-1:0]   p_tl, p_tr, p_bl, p_br;
   logic [BLK_W-1:0]    s1_block;
   logic [L1_W-1:0]     l1_c;

   // An accepted address 0 always restarts the frame at cell (0,0).
   assign sof_c   = (i_addr == '0);
   assign cur_col = sof_c ? '0 : col;
   assign cur_row = sof_c ? '0 : row;
   assign emit_c  = accept_c && (cur_row != '0) && (cur_col != '0);

   always_ff @(posedge clk) begin
      if (!rst) state <= WAIT_SOF;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      mismatch_c = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (i_valid && sof_c) begin
               accept_c  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (i_valid) begin
               if (i_addr == exp_addr) begin
                  accept_c = 1'b1;
               end else begin
                  mismatch_c = 1'b1;
                  if (sof_c) accept_c  = 1'b1;
                  else       state_nxt = WAIT_SOF;
               end
            end
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end

   // Position/block counters and pipeline valids.
   always_ff @(posedge clk) begin
      if (!rst) begin
         exp_addr <= '0;
         col      <= '0;
         row      <= '0;
         blk_cnt  <= '0;
         p_valid  <= 1'b0;
         s1_valid <= 1'b0;
         o_valid  <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         if (accept_c) begin
            exp_addr <= (i_addr == LAST_ADDR) ? '0 : i_addr + ADDR_W'(1);
            if (cur_col == LAST_COL) begin
               col <= '0;
               row <= (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
            end else begin
               col <= cur_col + COL_W'(1);
               row <= cur_row;
            end
            if (sof_c)       blk_cnt <= '0;
            else if (emit_c) blk_cnt <= blk_cnt + ADDR_W'(1);
         end
         if (mismatch_c) o_err <= 1'b1;
         p_valid  <= emit_c;
         s1_valid <= p_valid;
         o_valid  <= s1_valid;
      end
   end

   // Line buffer and data pipeline; read-before-write on prevrow.
   always_ff @(posedge clk) begin
      if (rst && accept_c) begin
         prevrow[cur_col] <= i_bin;
         p_tr             <= prevrow[cur_col];
         p_tl             <= p_tr;
         p_br             <= i_bin;
         p_bl             <= p_br;
         p_addr           <= blk_cnt;
      end
      if (rst && p_valid) begin
         s1_block <= {p_br, p_bl, p_tr, p_tl};
         s1_addr  <= p_addr;
      end
   end

   always_comb begin
      l1_c = '0;
      for (int i = 0; i < 36; i++) l1_c = l1_c + L1_W'(s1_block[i*BIN_W +: BIN_W]);
   end

   // Output registers hold their last block while o_valid is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_blk_addr <= '0;
         o_block    <= '0;
         o_l1       <= '0;
      end else if (s1_valid) begin
         o_blk_addr <= s1_addr;
         o_block    <= s1_block;
         o_l1       <= l1_c;
      end
   end

endmodule

// File: tb/tb_hog_block_gather.sv
// Bench for hog_block_gather: block stream from a frame-index reference model,
// compared with every captured output pulse including its arrival cycle.
module tb_hog_block_gather;
   localparam int COLS = 40;
   localparam int NC   = 1200;
   localparam int NB   = 1131;
   localparam int CW   = 288;
   localparam int BW   = 1152;
   localparam int LW   = 38;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_valid = 1'b0;
   logic [10:0]   i_addr = '0;
   logic [CW-1:0] i_bin = '0;
   logic          o_valid;
   logic [10:0]   o_blk_addr;
   logic [BW-1:0] o_block;
   logic [LW-1:0] o_l1;
   logic          o_err;

   hog_block_gather dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_addr(i_addr), .i_bin(i_bin),
      .o_valid(o_valid), .o_blk_addr(o_blk_addr), .o_block(o_block), .o_l1(o_l1), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [10:0]   addr;
      logic [BW-1:0] blk;
      logic [LW-1:0] l1;
   } ev_t;

   int            cyc = 0;
   int            tests = 0;
   int            fails = 0;
   ev_t           exp_q[$];
   ev_t           got_q[$];
   int            m_exp = -1;
   bit            m_err = 1'b0;
   logic [CW-1:0] fbin [NC];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ev_t cap;
      if (o_valid === 1'b1) begin
         cap.cyc = cyc; cap.addr = o_blk_addr; cap.blk = o_block; cap.l1 = o_l1;
         got_q.push_back(cap);
      end
   end

   function automatic logic [CW-1:0] make_bins(input int mode, input int n);
      logic [CW-1:0] b;
      for (int k = 0; k < 9; k++)
         case (mode)
            0:       b[k*32 +: 32] = 32'(n);
            1:       b[k*32 +: 32] = $urandom;
            default: b[k*32 +: 32] = '1;
         endcase
      return b;
   endfunction

   function automatic logic [LW-1:0] cell_sum(input logic [CW-1:0] b);
      logic [LW-1:0] s = '0;
      for (int k = 0; k < 9; k++) s += LW'(b[k*32 +: 32]);
      return s;
   endfunction

   // Frame-level reference: block (r,c) is cells n-41, n-40, n-1, n of the current frame.
   task automatic model_cell(input int a, input logic [CW-1:0] b, input int e);
      bit  acc = 1'b0;
      int  r, c;
      ev_t ev;
      if (m_exp < 0)        acc = (a == 0);
      else if (a == m_exp)  acc = 1'b1;
      else begin
         m_err = 1'b1;
         acc   = (a == 0);
         if (a != 0) m_exp = -1;
      end
      if (acc) begin
         fbin[a] = b;
         m_exp   = (a + 1) % NC;
         r = a / COLS;
         c = a % COLS;
         if (r >= 1 && c >= 1) begin
            ev.cyc  = e + 2;
            ev.addr = 11'((r - 1) * (COLS - 1) + (c - 1));
            ev.blk  = {b, fbin[a-1], fbin[a-COLS], fbin[a-COLS-1]};
            ev.l1   = cell_sum(b) + cell_sum(fbin[a-1]) + cell_sum(fbin[a-COLS]) + cell_sum(fbin[a-COLS-1]);
            exp_q.push_back(ev);
         end
      end
   endtask

   task automatic drive(input bit v, input int a, input logic [CW-1:0] b);
      int e = cyc + 1;
      i_valid = v; i_addr = 11'(a); i_bin = b;
      if (v) model_cell(a, b, e);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, '0);
   endtask

   task automatic send_frame(input int mode, input int gap_max);
      for (int n = 0; n < NC; n++) begin
         drive(1'b1, n, make_bins(mode, n));
         if (gap_max > 0) idle($urandom_range(1, gap_max));
      end
   endtask

   // Reset for one edge; blocks due at or after that edge are discarded.
   task automatic pulse_reset(input bit v, input int a);
      int e = cyc + 1;
      rst = 1'b0; i_valid = v; i_addr = 11'(a); i_bin = make_bins(1, 0);
      @(posedge clk); #1;
      m_exp = -1; m_err = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
   endtask

   function automatic int first_diff();
      int n = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
      for (int i = 0; i < n; i++)
         if (exp_q[i].cyc != got_q[i].cyc || exp_q[i].addr !== got_q[i].addr ||
             exp_q[i].blk !== got_q[i].blk || exp_q[i].l1 !== got_q[i].l1) return i;
      return -1;
   endfunction

   task automatic clear_q();
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset();
      pulse_reset(1'b1, 0);
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
      tests++; if (o_blk_addr !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", o_blk_addr); end
      tests++; if (o_block !== '0) begin fails++; $display("FAIL reset_block got nonzero want 0"); end
      tests++; if (o_l1 !== '0) begin fails++; $display("FAIL reset_l1 got %h want 0", o_l1); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", o_err); end
      rst = 1'b1;
      drive(1'b1, 5, make_bins(1, 5));
      idle(3);
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL wait_sof_ignore err got %b want 0", o_err); end
   endtask

   task automatic test_full_frame();
      int s, d;
      logic [BW-1:0] first_blk;
      clear_q();
      s = cyc + 1;
      send_frame(0, 0);
      idle(4);
      d = first_diff();
      first_blk = {make_bins(0, 41), make_bins(0, 40), make_bins(0, 1), make_bins(0, 0)};
      tests++; if (got_q.size() != NB) begin fails++; $display("FAIL full_count got %0d want %0d", got_q.size(), NB); end
      tests++; if (d != -1) begin fails++;
         $display("FAIL full_stream idx %0d got cyc %0d addr %0d l1 %h want cyc %0d addr %0d l1 %h", d,
                  got_q[d].cyc, got_q[d].addr, got_q[d].l1, exp_q[d].cyc, exp_q[d].addr, exp_q[d].l1); end
      tests++; if (got_q[0].cyc != s + 43 || got_q[0].addr !== 11'd0) begin fails++;
         $display("FAIL full_first got cyc %0d addr %0d want cyc %0d addr 0", got_q[0].cyc, got_q[0].addr, s + 43); end
      tests++; if (got_q[0].l1 !== 38'd738 || got_q[0].blk !== first_blk) begin fails++;
         $display("FAIL full_first_data got l1 %0d want 738", got_q[0].l1); end
      tests++; if (got_q[$].addr !== 11'd1130) begin fails++; $display("FAIL full_last_addr got %0d want 1130", got_q[$].addr); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL full_err got %b want 0", o_err); end
   endtask

   task automatic test_idle_gaps();
      int d;
      clear_q();
      send_frame(0, 5);
      idle(4);
      d = first_diff();
      tests++; if (got_q.size() != NB) begin fails++; $display("FAIL gaps_count got %0d want %0d", got_q.size(), NB); end
      tests++; if (d != -1) begin fails++;
         $display("FAIL gaps_stream idx %0d got cyc %0d addr %0d l1 %h want cyc %0d addr %0d l1 %h", d,
                  got_q[d].cyc, got_q[d].addr, got_q[d].l1, exp_q[d].cyc, exp_q[d].addr, exp_q[d].l1); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL gaps_err got %b want 0", o_err); end
   endtask

   task automatic test_saturate();
      int d;
      clear_q();
      send_frame(2, 0);
      idle(4);
      d = first_diff();
      tests++; if (d != -1 || got_q.size() != NB) begin fails++;
         $display("FAIL sat_stream idx %0d count %0d want -1 and %0d", d, got_q.size(), NB); end
      tests++; if (got_q[NB/2].l1 !== 38'h23_FFFF_FFDC) begin fails++;
         $display("FAIL sat_l1 got %h want 23ffffffdc", got_q[NB/2].l1); end
   endtask

   task automatic test_back_to_back();
      int d;
      clear_q();
      send_frame(1, 0);
      send_frame(1, 0);
      idle(4);
      d = first_diff();
      tests++; if (got_q.size() != 2*NB) begin fails++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 2*NB); end
      tests++; if (d != -1) begin fails++;
         $display("FAIL b2b_stream idx %0d got cyc %0d addr %0d l1 %h want cyc %0d addr %0d l1 %h", d,
                  got_q[d].cyc, got_q[d].addr, got_q[d].l1, exp_q[d].cyc, exp_q[d].addr, exp_q[d].l1); end
      tests++; if (got_q[NB].addr !== 11'd0 || got_q[2*NB-1].addr !== 11'd1130) begin fails++;
         $display("FAIL b2b_restart got %0d/%0d want 0/1130", got_q[NB].addr, got_q[2*NB-1].addr); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b want 0", o_err); end
   endtask

   task automatic test_seq_error();
      int d;
      clear_q();
      for (int n = 0; n <= 50; n++) drive(1'b1, n, make_bins(1, n));
      drive(1'b1, 53, make_bins(1, 53));
      for (int k = 0; k < 10; k++) drive(1'b1, $urandom_range(1, NC - 1), make_bins(1, k));
      idle(4);
      tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL seqerr_err got %b want 1", o_err); end
      tests++; if (got_q.size() != 10 || exp_q.size() != 10) begin fails++;
         $display("FAIL seqerr_count got %0d model %0d want 10", got_q.size(), exp_q.size()); end
      clear_q();
      send_frame(1, 0);
      idle(4);
      d = first_diff();
      tests++; if (got_q.size() != NB || d != -1) begin fails++;
         $display("FAIL seqerr_recover count %0d idx %0d want %0d -1", got_q.size(), d, NB); end
      tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL seqerr_sticky got %b want 1", o_err); end
   endtask

   task automatic test_reset_mid();
      int d, e;
      clear_q();
      for (int n = 0; n < 600; n++) drive(1'b1, n, make_bins(1, n));
      e = cyc + 1;
      pulse_reset(1'b1, 600);
      tests++; if (o_valid !== 1'b0 || o_l1 !== '0 || o_block !== '0 || o_blk_addr !== '0 || o_err !== 1'b0) begin
         fails++; $display("FAIL midrst_outputs got v %b l1 %h addr %0d err %b want all 0", o_valid, o_l1, o_blk_addr, o_err); end
      rst = 1'b1;
      idle(4);
      tests++; if (got_q.size() != exp_q.size() || got_q[$].cyc >= e) begin fails++;
         $display("FAIL midrst_stale got %0d last cyc %0d want %0d before %0d", got_q.size(), got_q[$].cyc, exp_q.size(), e); end
      clear_q();
      send_frame(1, 2);
      idle(4);
      d = first_diff();
      tests++; if (got_q.size() != NB || d != -1) begin fails++;
         $display("FAIL midrst_frame count %0d idx %0d want %0d -1", got_q.size(), d, NB); end
      tests++; if (got_q[0].addr !== 11'd0 || o_err !== 1'b0) begin fails++;
         $display("FAIL midrst_first got addr %0d err %b want 0 0", got_q[0].addr, o_err); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_idle_gaps();
      test_saturate();
      test_back_to_back();
      test_seq_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
